tp_mem_arbiter: RTL
===================

Name: tp_mem_arbiter

Overview:
- Shares one 512x16 two-port memory (one read port, one write port) between two write requesters (A, B) and two read requesters (A, B).
- Arbitrates each port independently, round-robin.
- Blocks same-address read/write collisions in the same cycle.
- Routes returned read data back to the requester that issued the read, tagged by source.
- Sits between the MVU data movers and the memory wrapper.

Parameters:
- AW, 9, address width (512 words).
- DW, 16, data word width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- wa_req  in  1  write requester A request
- wa_addr  in  AW  write A address
- wa_data  in  DW  write A data
- wa_gnt  out  1  write A granted this cycle (write accepted)
- wb_req, wb_addr, wb_data, wb_gnt  same as A, requester B
- ra_req  in  1  read requester A request
- ra_addr  in  AW  read A address
- ra_gnt  out  1  read A accepted this cycle
- ra_vld  out  1  read A data valid
- ra_data  out  DW  read A data
- rb_req, rb_addr, rb_gnt, rb_vld, rb_data  same as A, requester B
- mem_wr_en  out  1  memory write enable
- mem_wr_addr  out  AW  memory write address
- mem_wr_word  out  DW  memory write data
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  AW  memory read address
- mem_rd_word  in  DW  memory read data, valid the cycle after mem_rd_en

Behaviour:
- Reset (async, rst=1):
  - All grants, mem_wr_en, mem_rd_en, ra_vld, rb_vld = 0.
  - Both priority pointers point to A.
  - ra_data/rb_data = 0.
- Grants are combinational from req, addr and pointer state, gated low while rst=1.
- A request is accepted in any cycle its gnt=1. The requester holds req/addr/data stable until granted.
- Write arbitration:
  - One requester only: it is granted.
  - Both requesting: the pointer side wins.
  - After any grant, the write pointer moves to the non-granted side. With no grant, the pointer is held.
- Write port drive:
  - mem_wr_en = wa_gnt | wb_gnt.
  - mem_wr_addr/mem_wr_word are muxed from the granted side. When idle, they take A's values (don't-care).
- Read arbitration: same round-robin rule with an independent read pointer, producing a candidate read.
- Collision rule:
  - If a write is granted and the candidate read address equals mem_wr_addr in the same cycle, the read is not granted (both read gnts 0, mem_rd_en=0).
  - The read pointer is unchanged. The write always wins.
  - The other read requester is not substituted in that cycle, even if its address differs.
- Read port drive:
  - mem_rd_en = ra_gnt | rb_gnt.
  - mem_rd_addr is muxed from the granted side.
- Read return, 1-cycle latency:
  - A registered tag (valid bit + source bit) captures the grant.
  - In the next cycle, the matching rX_vld=1 for exactly one cycle and rX_data = mem_rd_word.
  - The other side's vld=0.
  - rX_data holds its last value when vld=0 (registered hold mux).
- Back-to-back reads by the same requester are allowed every cycle when uncontested. Each read produces its own vld pulse, in order.
- A write and a read to different addresses in the same cycle both proceed.
- A read of an address written in the previous cycle returns the new data (memory write-first across cycles).
- Reset asserted mid-operation:
  - Any in-flight read tag is discarded; no vld pulse follows.
  - Pointers return to A.

Test Plan:
- Reset, then wa_req=1 addr=0x005 data=0xBEEF alone -> wa_gnt=1, mem_wr_en=1, mem_wr_addr=0x005, mem_wr_word=0xBEEF in the same cycle.
- wa_req and wb_req held high for 4 cycles (addrs 0x010/0x011) -> grants alternate A,B,A,B. Exactly one mem_wr_en per cycle.
- After writing 0x1234 to 0x020, ra_req addr=0x020 -> ra_gnt=1 at cycle N, ra_vld=1 and ra_data=0x1234 at N+1, rb_vld=0.
- Same cycle: wb writes 0x020 and rb reads 0x020 -> wb_gnt=1, rb_gnt=0, mem_rd_en=0. Next cycle rb_gnt=1. Data returned one cycle later equals the newly written value.
- ra and rb both reading (0x030, 0x031) continuously with a write to 0x100 in parallel -> reads alternate each cycle, write uncontested. Vld pulses carry the correct per-source data.
- Assert rst the cycle after ra_gnt -> no ra_vld pulse, all outputs 0. After release, a contested read grants A first.

Source files
------------

// File: rtl/tp_mem_arbiter.sv
// Two-port memory arbiter: round-robin write and read ports, collision
// blocking, and tagged one-cycle read return to the issuing requester.
module tp_mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wa_req,
    input  logic [AW-1:0] wa_addr,
    input  logic [DW-1:0] wa_data,
    output logic          wa_gnt,
    input  logic          wb_req,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_gnt,
    input  logic          ra_req,
    input  logic [AW-1:0] ra_addr,
    output logic          ra_gnt,
    output logic          ra_vld,
    output logic [DW-1:0] ra_data,
    input  logic          rb_req,
    input  logic [AW-1:0] rb_addr,
    output logic          rb_gnt,
    output logic          rb_vld,
    output logic [DW-1:0] rb_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_word,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_word
);

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

    side_e         r_wptr;
    side_e         r_rptr;
    logic          r_tag_vld;
    logic          r_tag_src;
    logic [DW-1:0] r_ra_data;
    logic [DW-1:0] r_rb_data;

    logic          w_cand_a;
    logic          w_cand_b;
    logic [AW-1:0] w_cand_addr;
    logic          w_collide;

    // Write port: round-robin pick and memory write drive
    always_comb begin
        wa_gnt      = 1'b0;
        wb_gnt      = 1'b0;
        if (!rst) begin
            wa_gnt = wa_req & (~wb_req | (r_wptr == SIDE_A));
            wb_gnt = wb_req & (~wa_req | (r_wptr == SIDE_B));
        end
        mem_wr_en   = wa_gnt | wb_gnt;
        mem_wr_addr = wb_gnt ? wb_addr : wa_addr;
        mem_wr_word = wb_gnt ? wb_data : wa_data;
    end

    // Read port: candidate pick, then suppressed on a same-address write
    always_comb begin
        w_cand_a    = ra_req & (~rb_req | (r_rptr == SIDE_A));
        w_cand_b    = rb_req & (~ra_req | (r_rptr == SIDE_B));
        w_cand_addr = w_cand_b ? rb_addr : ra_addr;
        w_collide   = mem_wr_en & (w_cand_a | w_cand_b)
                    & (w_cand_addr == mem_wr_addr);
        ra_gnt      = 1'b0;
        rb_gnt      = 1'b0;
        if (!rst && !w_collide) begin
            ra_gnt = w_cand_a;
            rb_gnt = w_cand_b;
        end
        mem_rd_en   = ra_gnt | rb_gnt;
        mem_rd_addr = rb_gnt ? rb_addr : ra_addr;
    end

    // Pointers move to the non-granted side; held when nothing granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= SIDE_A;
            r_rptr <= SIDE_A;
        end else begin
            if (wa_gnt)
                r_wptr <= SIDE_B;
            else if (wb_gnt)
                r_wptr <= SIDE_A;
            if (ra_gnt)
                r_rptr <= SIDE_B;
            else if (rb_gnt)
                r_rptr <= SIDE_A;
        end
    end

    // Read tag: remembers who issued the read for the return cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= 1'b0;
            r_tag_src <= 1'b0;
        end else begin
            r_tag_vld <= ra_gnt | rb_gnt;
            r_tag_src <= rb_gnt;
        end
    end

    assign ra_vld  = r_tag_vld & ~r_tag_src;
    assign rb_vld  = r_tag_vld & r_tag_src;
    assign ra_data = ra_vld ? mem_rd_word : r_ra_data;
    assign rb_data = rb_vld ? mem_rd_word : r_rb_data;

    // Hold registers keep the last returned word between vld pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra_data <= '0;
            r_rb_data <= '0;
        end else begin
            if (ra_vld)
                r_ra_data <= mem_rd_word;
            if (rb_vld)
                r_rb_data <= mem_rd_word;
        end
    end

endmodule
